dev_bus_arbiter: RTL and testbench

Handshaked arbiter that shares the single I/O device bus among three CPU requesters (main, sub, sound). It replaces fixed time-slot bus rotation with request/acknowledge transactions, round-robin fairness and device wait-state support. It sits between the three CPU bus adapters and the device decode/RAM/IO fabric. A timeout guards against a device that never returns DEV_DV.

---
 rtl/dev_bus_arbiter_pkg.sv | 15 +
 rtl/dev_bus_arbiter_if.sv | 31 +++
 rtl/dev_bus_arbiter_rr_pick3.sv | 27 ++
 rtl/dev_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_dev_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types and constants for the three-requester device bus arbiter.
package dev_bus_arb_pkg;

  localparam int         NREQ          = 3;
  localparam logic [1:0] GNT_NONE      = 2'd3;
  localparam int         TO_CYCLES_DEF = 64;
  localparam logic [7:0] TO_DATA_DEF   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } arb_state_e;

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// Requester-side and device-side bus signals of the arbiter, grouped as one interface.
interface dev_bus_arbiter_if;
  import dev_bus_arb_pkg::*;

  logic [NREQ-1:0]    RQ_REQ;
  logic [16*NREQ-1:0] RQ_AD;
  logic [NREQ-1:0]    RQ_WR;
  logic [8*NREQ-1:0]  RQ_DO;
  logic [NREQ-1:0]    RQ_ACK;
  logic [7:0]         RQ_DI;
  logic [15:0]        DEV_AD;
  logic               DEV_RD;
  logic               DEV_WR;
  logic [7:0]         DEV_DI;
  logic               DEV_DV;
  logic [7:0]         DEV_DO;
  logic [1:0]         GNT;
  logic               TOERR;

  // The arbiter is the slave of the requesters and drives the device side.
  modport slave (
    input  RQ_REQ, RQ_AD, RQ_WR, RQ_DO, DEV_DV, DEV_DO,
    output RQ_ACK, RQ_DI, DEV_AD, DEV_RD, DEV_WR, DEV_DI, GNT, TOERR
  );

  modport master (
    output RQ_REQ, RQ_AD, RQ_WR, RQ_DO, DEV_DV, DEV_DO,
    input  RQ_ACK, RQ_DI, DEV_AD, DEV_RD, DEV_WR, DEV_DI, GNT, TOERR
  );

endinterface

// File: rtl/dev_bus_arbiter_rr_pick3.sv
// Combinational round-robin picker: first set request searching last+1, last+2, last (mod 3).
module rr_pick3
  import dev_bus_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      win
);

  logic [1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
  always_comb begin
    valid = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        valid = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Request/acknowledge arbiter sharing one device bus among three CPUs, with
// round-robin fairness, device wait states and a read timeout.
module dev_bus_arbiter
  import dev_bus_arb_pkg::*;
#(
  parameter int         TO_CYCLES = TO_CYCLES_DEF,
  parameter logic [7:0] TO_DATA   = TO_DATA_DEF
) (
  input logic            MCLK,
  input logic            RESET_N,
  dev_bus_arbiter_if.slave bus
);

  localparam int             CNT_W    = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [15:0]     ad_q, ad_d;
  logic [7:0]      di_q, di_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      rqdi_q, rqdi_d;
  logic            toerr_q, toerr_d;

  logic            pick_valid;
  logic [1:0]      pick_win;

  rr_pick3 u_pick (
    .req   (bus.RQ_REQ),
    .last  (last_q),
    .valid (pick_valid),
    .win   (pick_win)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    ad_d    = ad_q;
    di_d    = di_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    ack_d   = '0;
    rqdi_d  = rqdi_q;
    toerr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = GNT_NONE;
        if (pick_valid) begin
          state_d = ACCESS;
          gnt_d   = pick_win;
          last_d  = pick_win;
          cnt_d   = '0;
          is_wr_d = bus.RQ_WR[pick_win];
          ad_d    = bus.RQ_AD[16*pick_win +: 16];
          di_d    = bus.RQ_DO[8*pick_win +: 8];
          rd_d    = ~bus.RQ_WR[pick_win];
          wr_d    = bus.RQ_WR[pick_win];
        end
      end
      ACCESS: begin
        if (is_wr_q) begin
          state_d = ACK;
          ack_d   = NREQ'(1) << gnt_q;
        end else if (bus.DEV_DV) begin
          state_d = ACK;
          ack_d   = NREQ'(1) << gnt_q;
          rqdi_d  = bus.DEV_DO;
        end else if (cnt_q == CNT_LAST) begin
          // Device never answered: complete with a marker value and flag it.
          state_d = ACK;
          ack_d   = NREQ'(1) << gnt_q;
          rqdi_d  = TO_DATA;
          toerr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          rd_d  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      gnt_q   <= GNT_NONE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      ad_q    <= '0;
      di_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      rqdi_q  <= '0;
      toerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      ad_q    <= ad_d;
      di_q    <= di_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      rqdi_q  <= rqdi_d;
      toerr_q <= toerr_d;
    end
  end

  assign bus.RQ_ACK = ack_q;
  assign bus.RQ_DI  = rqdi_q;
  assign bus.DEV_AD = ad_q;
  assign bus.DEV_RD = rd_q;
  assign bus.DEV_WR = wr_q;
  assign bus.DEV_DI = di_q;
  assign bus.GNT    = gnt_q;
  assign bus.TOERR  = toerr_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: directed vector table, reset/contention
// sequence and randomized traffic against a transaction-level scheduling model.
module tb_dev_bus_arbiter;

  logic MCLK = 1'b0;
  logic RESET_N;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   dv_delay = 0;
  int   rd_cnt = 0;

  always #5 MCLK = ~MCLK;

  dev_bus_arbiter_if bus();

  dev_bus_arbiter #(.TO_CYCLES(64), .TO_DATA(8'hFF)) dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // Device model: raises DV dv_delay cycles into a read strobe (-1 = never).
  always @(posedge MCLK) begin
    #1;
    if (bus.DEV_RD) begin
      bus.DEV_DV = (dv_delay >= 0 && rd_cnt >= dv_delay);
      rd_cnt++;
    end else begin
      bus.DEV_DV = 1'b0;
      rd_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    bus.RQ_REQ = '0;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  typedef struct {
    int         req;
    bit         wr;
    logic [15:0] ad;
    logic [7:0] wd;
    int         dv;
    logic [7:0] dd;
    logic [2:0] exp_ack;
    int         exp_lat;
    int         exp_rd;
    int         exp_wr;
    logic [7:0] exp_rqdi;
    int         exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 0, nrd = 0, nwr = 0, nto = 0;
    bit got = 0;
    logic [15:0] ad_seen = '0;
    logic [7:0] di_seen = '0;
    logic [2:0] ack_seen = '0;
    dv_delay = v.dv;
    bus.DEV_DO = v.dd;
    bus.RQ_AD[16*v.req +: 16] = v.ad;
    bus.RQ_DO[8*v.req +: 8] = v.wd;
    bus.RQ_WR[v.req] = v.wr;
    bus.RQ_REQ[v.req] = 1'b1;
    while (!got && lat < 200) begin
      tick();
      lat++;
      if (bus.DEV_RD) nrd++;
      if (bus.DEV_WR) nwr++;
      if ((bus.DEV_RD || bus.DEV_WR) && (nrd + nwr) == 1) begin
        ad_seen = bus.DEV_AD;
        di_seen = bus.DEV_DI;
      end
      if (bus.TOERR) nto++;
      if (bus.RQ_ACK != 0) begin
        got = 1;
        ack_seen = bus.RQ_ACK;
      end
    end
    check($sformatf("v%0d_ack", idx), 32'(ack_seen), 32'(v.exp_ack));
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_rd_cycles", idx), nrd, v.exp_rd);
    check($sformatf("v%0d_wr_cycles", idx), nwr, v.exp_wr);
    check($sformatf("v%0d_dev_ad", idx), 32'(ad_seen), 32'(v.ad));
    check($sformatf("v%0d_dev_di", idx), 32'(di_seen), 32'(v.wd));
    check($sformatf("v%0d_rq_di", idx), 32'(bus.RQ_DI), 32'(v.exp_rqdi));
    check($sformatf("v%0d_toerr", idx), nto, v.exp_to);
    tick();
    bus.RQ_REQ[v.req] = 1'b0;
    tick();
  endtask

  function automatic int rr_model(input bit p[3], input int last);
    for (int k = 1; k <= 3; k++)
      if (p[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int exp_order[3] = '{0, 1, 2};
    int k, prev, rel;
    int drop_at[3], raise_at[3];
    bit pend[3];
    int g, L, ack_t, w, free_at, t, dvd, r;
    bit g_wr, g_to;
    logic [15:0] g_ad, m_ad;
    logic [7:0] g_di, g_data, m_di, m_rqdi;

    //           req wr ad        wd     dv  dd     ack     lat rd  wr rqdi   to
    vecs[0] = '{1, 0, 16'h8000, 8'h11, 0,  8'h5A, 3'b010, 2,  1,  0, 8'h5A, 0};
    vecs[1] = '{0, 1, 16'h6800, 8'h3C, 0,  8'h00, 3'b001, 2,  0,  1, 8'h5A, 0};
    vecs[2] = '{2, 0, 16'h1234, 8'h22, 5,  8'hA7, 3'b100, 7,  6,  0, 8'hA7, 0};
    vecs[3] = '{0, 0, 16'h4000, 8'h33, -1, 8'h00, 3'b001, 65, 64, 0, 8'hFF, 1};
    vecs[4] = '{1, 0, 16'hC0DE, 8'h44, 63, 8'h81, 3'b010, 65, 64, 0, 8'h81, 0};
    vecs[5] = '{2, 1, 16'h00FF, 8'h55, 0,  8'h00, 3'b100, 2,  0,  1, 8'h81, 0};

    bus.RQ_REQ = '0;
    bus.RQ_AD = '0;
    bus.RQ_WR = '0;
    bus.RQ_DO = '0;
    bus.DEV_DO = '0;
    do_reset();

    check("rst_ack", 32'(bus.RQ_ACK), 0);
    check("rst_rq_di", 32'(bus.RQ_DI), 0);
    check("rst_dev_ad", 32'(bus.DEV_AD), 0);
    check("rst_dev_rd", 32'(bus.DEV_RD), 0);
    check("rst_dev_wr", 32'(bus.DEV_WR), 0);
    check("rst_dev_di", 32'(bus.DEV_DI), 0);
    check("rst_gnt", 32'(bus.GNT), 3);
    check("rst_toerr", 32'(bus.TOERR), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset in the middle of a read, then all three requesters contend from reset.
    dv_delay = -1;
    bus.RQ_AD[15:0] = 16'h2222;
    bus.RQ_WR[0] = 1'b0;
    bus.RQ_REQ[0] = 1'b1;
    tick(); tick(); tick();
    check("mid_rd_active", 32'(bus.DEV_RD), 1);
    RESET_N = 1'b0;
    bus.RQ_REQ = 3'b111;
    bus.RQ_WR = 3'b111;
    tick();
    check("mid_rd_dropped", 32'(bus.DEV_RD), 0);
    check("mid_gnt_none", 32'(bus.GNT), 3);
    check("mid_no_ack", 32'(bus.RQ_ACK), 0);
    check("mid_rq_di", 32'(bus.RQ_DI), 0);
    tick();
    check("mid_no_ack_2", 32'(bus.RQ_ACK), 0);
    RESET_N = 1'b1;
    rel = cyc;
    k = 0;
    prev = -1;
    for (int i = 0; i < 3; i++) begin drop_at[i] = -1; raise_at[i] = -1; end
    for (int n = 0; n < 60 && k < 6; n++) begin
      tick();
      for (int i = 0; i < 3; i++) if (raise_at[i] == cyc) bus.RQ_REQ[i] = 1'b1;
      for (int i = 0; i < 3; i++)
        if (drop_at[i] == cyc) begin bus.RQ_REQ[i] = 1'b0; raise_at[i] = cyc + 1; end
      if (bus.RQ_ACK != 0) begin
        check($sformatf("cont_order%0d", k), 32'(bus.RQ_ACK), 32'(1) << exp_order[k % 3]);
        check($sformatf("cont_gap%0d", k), cyc - ((k == 0) ? rel : prev), (k == 0) ? 2 : 3);
        drop_at[exp_order[k % 3]] = cyc + 1;
        prev = cyc;
        k++;
      end
    end
    check("cont_count", k, 6);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 3; i++) begin pend[i] = 0; drop_at[i] = -1; end
    free_at = cyc;
    g = -100; L = 0; ack_t = -100; w = 0; g_wr = 0; g_to = 0;
    g_ad = '0; g_di = '0; g_data = '0;
    m_ad = '0; m_di = '0; m_rqdi = '0;
    r = 2;
    for (int n = 0; n < 2500; n++) begin
      t = cyc;
      for (int i = 0; i < 3; i++)
        if (drop_at[i] == t) begin pend[i] = 0; bus.RQ_REQ[i] = 1'b0; end
      for (int i = 0; i < 3; i++)
        if (!pend[i] && drop_at[i] != t && $urandom_range(2) == 0) begin
          pend[i] = 1;
          bus.RQ_AD[16*i +: 16] = 16'($urandom);
          bus.RQ_DO[8*i +: 8] = 8'($urandom);
          bus.RQ_WR[i] = 1'($urandom);
          bus.RQ_REQ[i] = 1'b1;
        end
      if (t >= free_at && rr_model(pend, r) >= 0) begin
        w = rr_model(pend, r);
        r = w;
        g = t + 1;
        g_wr = bus.RQ_WR[w];
        g_ad = bus.RQ_AD[16*w +: 16];
        g_di = bus.RQ_DO[8*w +: 8];
        case ($urandom_range(15))
          0: dvd = -1;
          1: dvd = 63;
          default: dvd = int'($urandom_range(6));
        endcase
        dv_delay = dvd;
        g_data = 8'($urandom);
        bus.DEV_DO = g_data;
        L = g_wr ? 1 : ((dvd < 0) ? 64 : dvd + 1);
        g_to = !g_wr && dvd < 0;
        ack_t = g + L;
        free_at = ack_t + 1;
        drop_at[w] = ack_t + 1;
      end
      tick();
      t = cyc;
      if (t == g) begin m_ad = g_ad; m_di = g_di; end
      if (t == ack_t && !g_wr) m_rqdi = g_to ? 8'hFF : g_data;
      check("rnd_ack", 32'(bus.RQ_ACK), (t == ack_t) ? (32'(1) << w) : 0);
      check("rnd_gnt", 32'(bus.GNT), (t >= g && t <= ack_t) ? w : 3);
      check("rnd_rd", 32'(bus.DEV_RD), 32'(t >= g && t < ack_t && !g_wr));
      check("rnd_wr", 32'(bus.DEV_WR), 32'(t >= g && t < ack_t && g_wr));
      check("rnd_toerr", 32'(bus.TOERR), 32'(t == ack_t && g_to));
      check("rnd_dev_ad", 32'(bus.DEV_AD), 32'(m_ad));
      check("rnd_dev_di", 32'(bus.DEV_DI), 32'(m_di));
      check("rnd_rq_di", 32'(bus.RQ_DI), 32'(m_rqdi));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
